uart_tx_mmio: RTL

Memory-mapped UART transmitter at `0x4000_2000` on the CPU data bus. It accepts byte stores (`sb`), buffers them in a small FIFO and serializes each one as 8N1 on the board's TX pin. Boot code can store a string back-to-back without polling: the block stalls the CPU only when the FIFO is full. A status register is provided for software that prefers to poll.

---
 rtl/uart_tx_mmio_pkg.sv | 22 ++
 rtl/uart_fifo.sv | 63 ++++++
 rtl/uart_tx_mmio.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: register offsets, STATUS bit positions, default base
// address and the serializer state encoding.
package uart_tx_mmio_pkg;

    localparam logic [2:0]  UART_DATA         = 3'd0;
    localparam logic [2:0]  UART_STATUS       = 3'd4;

    localparam int unsigned ST_BUSY           = 0;
    localparam int unsigned ST_FULL           = 1;
    localparam int unsigned ST_EMPTY          = 2;

    localparam logic [31:0] UART_BASE_DEFAULT = 32'h4000_2000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO for the UART transmitter.
// Ports:
//   clk, reset       - rising-edge clock, asynchronous active-high reset
//   i_push, i_din    - write request and data (ignored while full)
//   i_pop            - read request (ignored while empty)
//   o_dout           - head entry, valid while not empty
//   o_full, o_empty  - derived from the registered occupancy count
//   o_count          - number of stored entries
module uart_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [7:0]                 i_din,
    input  logic                       i_pop,
    output logic [7:0]                 o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage is not reset; flushing the pointers is enough.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO.
// Ports:
//   clk, reset   - rising-edge clock, asynchronous active-high reset
//   bus_addr     - CPU byte address; block decoded on bits [31:3]
//   bus_wdata    - store data (byte lane 0), pushed on DATA writes
//   bus_we       - write strobe
//   bus_re       - read strobe
//   bus_rdata    - combinational read data (STATUS only, else 0)
//   bus_wait     - combinational stall while a DATA write meets a full FIFO
//   tx           - registered serial output, idle high
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 12_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = UART_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [7:0]  bus_rdata,
    output logic        bus_wait,
    output logic        tx
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    tx_state_t        r_state, w_state_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [2:0]       r_bit, w_bit_next;
    logic [7:0]       r_shift, w_shift_next;
    logic             r_tx, w_tx_next;

    logic             w_sel, w_data_sel, w_stat_sel;
    logic             w_push, w_pop;
    logic [7:0]       w_fifo_dout;
    logic             w_full, w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic             w_busy;
    logic             w_baud_end;
    logic [7:0]       w_status;

    assign w_sel      = (bus_addr[31:3] == BASE_ADDR[31:3]);
    assign w_data_sel = w_sel && (bus_addr[2:0] == UART_DATA);
    assign w_stat_sel = w_sel && (bus_addr[2:0] == UART_STATUS);

    // Push legality uses only the registered full flag; no pop bypass.
    assign w_push   = w_data_sel & bus_we & ~w_full;
    assign bus_wait = ~reset & w_data_sel & bus_we & w_full;

    assign w_busy = (r_state != S_IDLE) | (w_count != '0);

    always_comb begin
        w_status           = '0;
        w_status[ST_BUSY]  = w_busy;
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
    end

    assign bus_rdata = (~reset & w_stat_sel & bus_re) ? w_status : '0;
    assign tx        = r_tx;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (bus_wdata),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_baud_end = (r_cnt == CW'(DIV - 1));

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_cnt_next   = '0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = S_DATA;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_cnt_next   = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next   = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_cnt_next = '0;
                    // Chain straight into the next start bit when data is queued.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_dout;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // tx is registered from the next state so the start bit appears
        // on the same edge that pops the byte.
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

endmodule
